// File: rtl/bsram_pkg.sv
// Shared constants, state encoding and helpers for the parametrised
// single-port block-RAM wrapper.
package bsram_pkg;

  localparam int READ_BYPASS   = 0;
  localparam int READ_PIPE     = 1;

  localparam int WR_NORMAL     = 0;
  localparam int WR_THROUGH    = 1;
  localparam int WR_READ_FIRST = 2;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  function automatic int lanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/bsram_sp_array.sv
// Inferred single-port memory: per-lane write enables and a registered read
// port whose content on a write follows the selected write mode.
module bsram_sp_array
  import bsram_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LANE_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int WRITE_MODE = WR_NORMAL,
  localparam int NL        = lanes(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              we,
  input  logic              load,
  input  logic [NL-1:0]     be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;

  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

  // Storage has no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NL; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // load is low during the clear sweep so sweep writes never reach q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en && load) begin
      if (!we) begin
        q <= old_word;
      end else if (WRITE_MODE == WR_THROUGH) begin
        q <= merged;
      end else if (WRITE_MODE == WR_READ_FIRST) begin
        q <= old_word;
      end
    end
  end

endmodule

// File: rtl/bsram_sp_pipe.sv
// Single-port block-RAM wrapper: post-reset clear sweep, access muxing,
// read-valid tracking and an optional oce-gated output register.
module bsram_sp_pipe
  import bsram_pkg::*;
#(
  parameter int DATA_W                = 16,
  parameter int LANE_W                = 8,
  parameter int ADDR_W                = 10,
  parameter int READ_MODE             = READ_BYPASS,
  parameter int WRITE_MODE            = WR_NORMAL,
  parameter int CLEAR_ON_RESET        = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  localparam int NL                   = lanes(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic [NL-1:0]     be,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output state_t            dbg_state
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              acc;
  logic              q1_valid;
  logic [DATA_W-1:0] q1;

  logic              mem_en;
  logic              mem_we;
  logic [NL-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (&cnt) state_nx = ST_IDLE;
      ST_IDLE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_CLEAR);
  assign dbg_state = state;
  assign acc       = ce & ~busy;

  // The sweep owns the port while busy; user inputs are ignored.
  assign mem_en    = busy | acc;
  assign mem_we    = busy | wre;
  assign mem_be    = busy ? {NL{1'b1}} : be;
  assign mem_addr  = busy ? cnt : ad;
  assign mem_wdata = busy ? CLEAR_VALUE : din;

  bsram_sp_array #(
    .DATA_W    (DATA_W),
    .LANE_W    (LANE_W),
    .ADDR_W    (ADDR_W),
    .WRITE_MODE(WRITE_MODE)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (mem_en),
    .we     (mem_we),
    .load   (acc),
    .be     (mem_be),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .q      (q1)
  );

  // A normal-mode write returns no data, so it does not raise valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1_valid <= 1'b0;
    end else begin
      q1_valid <= acc & (~wre | (WRITE_MODE != WR_NORMAL));
    end
  end

  generate
    if (READ_MODE == READ_PIPE) begin : g_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else if (oce) begin
          dout       <= q1;
          dout_valid <= q1_valid;
        end
      end
    end else begin : g_bypass
      logic unused_oce;
      assign unused_oce = oce;
      assign dout       = q1;
      assign dout_valid = q1_valid;
    end
  endgenerate

endmodule
